// File: rtl/max_scan_ctrl.sv
// Frame maximum-select controller: streams LEN samples through a registered
// unsigned greater-than compare and reports the maximum, its index and a done pulse.
module max_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] max_out,
  output logic [LEN_W-1:0] max_idx,
  output logic             busy,
  output logic             done,
  output logic             out_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_q;
  logic             accept;
  logic             last;
  logic             start_ok;

  assign in_ready = (state == S_SCAN);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign accept   = in_valid && in_ready;
  assign last     = (count == len_q - LEN_W'(1));
  assign start_ok = (state == S_IDLE) && start;

  // NOTE: combinational blocks assign every output a default first so that
  // no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (len == '0) ? S_DONE : S_SCAN;
      S_SCAN: if (accept && last) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      len_q     <= '0;
      max_out   <= '0;
      max_idx   <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        len_q     <= len;
        count     <= '0;
        max_out   <= '0;
        max_idx   <= '0;
        out_valid <= 1'b0;
      end
      if (accept) begin
        count <= count + LEN_W'(1);
        // First sample loads unconditionally; strict compare keeps the earliest index on ties.
        if (count == '0 || in_data > max_out) begin
          max_out <= in_data;
          max_idx <= count;
        end
      end
      if (state == S_DONE) out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_max_scan_ctrl.sv
// Directed self-checking bench for max_scan_ctrl: inputs change and outputs are
// checked on the falling edge; the DUT acts on the rising edge.
module tb_max_scan_ctrl;

  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] max_out;
  logic [LEN_W-1:0] max_idx;
  logic             busy;
  logic             done;
  logic             out_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  max_scan_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .max_out   (max_out),
    .max_idx   (max_idx),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after start is taken.
  task automatic do_start(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] m, input logic [LEN_W-1:0] i);
    check({tag, "_done"},  32'(done), 32'd1);
    check({tag, "_max"},   32'(max_out), 32'(m));
    check({tag, "_idx"},   32'(max_idx), 32'(i));
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_ov0"},   32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_nodone"}, 32'(done), 32'd0);
    check({tag, "_idle"},   32'(busy), 32'd0);
    check({tag, "_ov1"},    32'(out_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_ov",    32'(out_valid), 32'd0);
    check("rst_max",   32'(max_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1. Mid-frame asynchronous reset
    do_start(4'd4);
    check("t1_ready", 32'(in_ready), 32'd1);
    send(8'h11);
    send(8'h22);
    check("t1_run_max", 32'(max_out), 32'h22);
    check("t1_run_idx", 32'(max_idx), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t1_ar_ready", 32'(in_ready), 32'd0);
    check("t1_ar_busy",  32'(busy), 32'd0);
    check("t1_ar_max",   32'(max_out), 32'd0);
    check("t1_ar_idx",   32'(max_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(4'd1);
    send(8'h09);
    check_result("t1_len1", 8'h09, 4'd0);

    // 2. Back-to-back samples
    do_start(4'd4);
    send(8'h12);
    send(8'h7F);
    send(8'h33);
    check("t2_ready3", 32'(in_ready), 32'd1);
    check("t2_nodone3", 32'(done), 32'd0);
    send(8'h05);
    check_result("t2", 8'h7F, 4'd1);
    repeat (2) @(negedge clk);
    check("t2_ov_hold", 32'(out_valid), 32'd1);
    check("t2_max_hold", 32'(max_out), 32'h7F);

    // 3. Ties and unsigned compare
    do_start(4'd3);
    check("t3_ov_clr", 32'(out_valid), 32'd0);
    check("t3_max_clr", 32'(max_out), 32'd0);
    send(8'h40); send(8'h40); send(8'h40);
    check_result("t3_tie", 8'h40, 4'd0);
    do_start(4'd2);
    send(8'h7F); send(8'h80);
    check_result("t3_uns", 8'h80, 4'd1);

    // 4. Bubbles
    do_start(4'd2);
    send(8'h01);
    in_data = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      check("t4_bub_done", 32'(done), 32'd0);
      check("t4_bub_busy", 32'(busy), 32'd1);
      check("t4_bub_max",  32'(max_out), 32'h01);
      @(negedge clk);
    end
    send(8'hFF);
    check_result("t4", 8'hFF, 4'd1);

    // 5. Zero length; in_valid in IDLE is not consumed
    in_valid = 1'b1;
    in_data  = 8'h55;
    check("t5_idle_ready", 32'(in_ready), 32'd0);
    do_start(4'd0);
    in_valid = 1'b0;
    check("t5_busy", 32'(busy), 32'd1);
    check_result("t5", 8'h00, 4'd0);

    // 6. Maximum length with a start pulse mid-frame
    do_start(4'd15);
    for (int k = 0; k < 14; k++) begin
      if (k == 7) begin
        start = 1'b1;
        len   = 4'd3;
      end
      send(8'(k));
      start = 1'b0;
    end
    check("t6_nodone14", 32'(done), 32'd0);
    check("t6_run_max", 32'(max_out), 32'h0D);
    check("t6_run_idx", 32'(max_idx), 32'd13);
    send(8'hFF);
    check_result("t6", 8'hFF, 4'd14);
    @(negedge clk);
    check("t6_no_frame", 32'(busy), 32'd0);
    check("t6_no_done",  32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
